// File: rtl/branch_predictor_if.sv
// Fetch/resolve bus between the pipeline and the branch predictor.
// The pipeline drives the master side; the predictor sits on the slave side.
interface branch_predictor_if #(
  parameter int width = 32
);
  logic [width-1:0] fetch_pc_i;
  logic             pred_taken_o;
  logic [width-1:0] pred_target_o;
  logic             stall_i;
  logic             upd_valid_i;
  logic [width-1:0] upd_pc_i;
  logic             upd_taken_i;
  logic [width-1:0] upd_target_i;
  logic             upd_pred_taken_i;
  logic [width-1:0] upd_pred_target_i;
  logic             mispredict_o;
  logic [width-1:0] redirect_addr_o;
  logic [31:0]      br_count_o;
  logic [31:0]      mispred_count_o;

  modport master (
    output fetch_pc_i, stall_i, upd_valid_i, upd_pc_i, upd_taken_i,
           upd_target_i, upd_pred_taken_i, upd_pred_target_i,
    input  pred_taken_o, pred_target_o, mispredict_o, redirect_addr_o,
           br_count_o, mispred_count_o
  );

  modport slave (
    input  fetch_pc_i, stall_i, upd_valid_i, upd_pc_i, upd_taken_i,
           upd_target_i, upd_pred_taken_i, upd_pred_target_i,
    output pred_taken_o, pred_target_o, mispredict_o, redirect_addr_o,
           br_count_o, mispred_count_o
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency fetch lookup,
// resolve-stage update, misprediction detection and branch statistics.
module branch_predictor #(
  parameter int width    = 32,
  parameter int idx_bits = 4
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);
  localparam int entries = 1 << idx_bits;
  localparam int tag_w   = width - idx_bits - 2;

  typedef struct packed {
    logic             valid;
    logic [tag_w-1:0] tag;
    logic [width-1:0] target;
    logic [1:0]       ctr;
  } btb_entry_t;

  btb_entry_t btb [entries];
  logic [31:0] br_cnt;
  logic [31:0] mis_cnt;

  // fetch-side lookup
  logic [idx_bits-1:0] f_idx;
  logic [tag_w-1:0]    f_tag;
  btb_entry_t          f_ent;
  logic                f_hit;

  always_comb begin
    f_idx = bp.fetch_pc_i[idx_bits+1:2];
    f_tag = bp.fetch_pc_i[width-1:idx_bits+2];
    f_ent = btb[f_idx];
    f_hit = f_ent.valid && (f_ent.tag == f_tag);
  end

  assign bp.pred_taken_o  = f_hit && f_ent.ctr[1];
  assign bp.pred_target_o = (f_hit && f_ent.ctr[1]) ? f_ent.target
                                                    : bp.fetch_pc_i + width'(4);

  // resolve-side checks are combinational so a stalled update keeps flagging
  assign bp.mispredict_o = bp.upd_valid_i &&
                           ((bp.upd_pred_taken_i != bp.upd_taken_i) ||
                            (bp.upd_taken_i && (bp.upd_pred_target_i != bp.upd_target_i)));
  assign bp.redirect_addr_o = bp.upd_taken_i ? bp.upd_target_i
                                             : bp.upd_pc_i + width'(4);

  logic [idx_bits-1:0] u_idx;
  logic [tag_w-1:0]    u_tag;
  btb_entry_t          u_cur;
  btb_entry_t          u_new;
  logic                u_hit;
  logic                u_wr;
  logic                u_en;

  always_comb begin
    u_idx = bp.upd_pc_i[idx_bits+1:2];
    u_tag = bp.upd_pc_i[width-1:idx_bits+2];
    u_cur = btb[u_idx];
    u_hit = u_cur.valid && (u_cur.tag == u_tag);
    u_en  = bp.upd_valid_i && !bp.stall_i;
    u_new = u_cur;
    u_wr  = 1'b0;
    if (u_hit) begin
      u_wr = 1'b1;
      if (bp.upd_taken_i) begin
        u_new.target = bp.upd_target_i;
        if (u_cur.ctr != 2'b11) u_new.ctr = u_cur.ctr + 2'd1;
      end else if (u_cur.ctr != 2'b00) begin
        u_new.ctr = u_cur.ctr - 2'd1;
      end
    end else if (bp.upd_taken_i) begin
      // miss on a taken transfer replaces whatever lives at this index
      u_wr         = 1'b1;
      u_new.valid  = 1'b1;
      u_new.tag    = u_tag;
      u_new.target = bp.upd_target_i;
      u_new.ctr    = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < entries; i++)
        btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else if (u_en) begin
      if (u_wr) btb[u_idx] <= u_new;
      br_cnt <= br_cnt + 32'd1;
      if (bp.mispredict_o) mis_cnt <= mis_cnt + 32'd1;
    end
  end

  assign bp.br_count_o      = br_cnt;
  assign bp.mispred_count_o = mis_cnt;
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, hand sequences for
// stall/wrap/reset, then random traffic against an array-based reference model.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if #(.width(32)) bif ();
  branch_predictor #(.width(32), .idx_bits(4)) dut (.clk(clk), .rst(rst), .bp(bif.slave));

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] fpc, input logic v, input logic [31:0] upc,
                       input logic t, input logic [31:0] tg, input logic pt,
                       input logic [31:0] ptg, input logic st);
    bif.fetch_pc_i        = fpc;
    bif.upd_valid_i       = v;
    bif.upd_pc_i          = upc;
    bif.upd_taken_i       = t;
    bif.upd_target_i      = tg;
    bif.upd_pred_taken_i  = pt;
    bif.upd_pred_target_i = ptg;
    bif.stall_i           = st;
  endtask

  task automatic idle_fetch(input logic [31:0] fpc);
    drive(fpc, 1'b0, fpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // ---------------- reference model: plain arrays of integers ----------------
  bit          m_valid [16];
  int unsigned m_tag   [16];
  int unsigned m_tgt   [16];
  int          m_ctr   [16];
  int unsigned m_br, m_mis;

  function automatic bit m_hit(input int unsigned pc);
    return m_valid[(pc / 4) % 16] && (m_tag[(pc / 4) % 16] == pc / 64);
  endfunction

  task automatic m_predict(input int unsigned pc, output bit taken, output int unsigned tgt);
    taken = m_hit(pc) && (m_ctr[(pc / 4) % 16] >= 2);
    tgt   = taken ? m_tgt[(pc / 4) % 16] : pc + 4;
  endtask

  function automatic bit m_mispred(input bit v, input bit t, input int unsigned tg,
                                   input bit pt, input int unsigned ptg);
    return v && ((pt != t) || (t && ptg != tg));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_br = 0; m_mis = 0;
  endtask

  task automatic m_commit(input bit r, input bit v, input bit st, input int unsigned pc,
                          input bit t, input int unsigned tg, input bit pt, input int unsigned ptg);
    int i;
    i = (pc / 4) % 16;
    if (r) m_reset();
    else if (v && !st) begin
      m_br++;
      if (m_mispred(v, t, tg, pt, ptg)) m_mis++;
      if (m_hit(pc)) begin
        m_ctr[i] = t ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1)
                     : ((m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1);
        if (t) m_tgt[i] = tg;
      end else if (t) begin
        m_valid[i] = 1; m_tag[i] = pc / 64; m_tgt[i] = tg; m_ctr[i] = 2;
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] fpc;
    logic        v;
    logic [31:0] upc;
    logic        t;
    logic [31:0] tg;
    logic        pt;
    logic [31:0] ptg;
    logic        e_pt;
    logic [31:0] e_ptg;
    logic        e_mis;
    logic [31:0] e_red;
    logic [31:0] e_br;
    logic [31:0] e_mcnt;
  } vec_t;

  vec_t tbl [19];

  initial begin
    // fetch  v  upc  t  tg  pt ptg | pred  tgt  mis  redirect  br  mis
    tbl[0]  = '{32'h100, 0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h104, 0,  0};
    tbl[1]  = '{32'h100, 1, 32'h100, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80,  1,  1};
    tbl[2]  = '{32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80,  2,  1};
    tbl[3]  = '{32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80,  3,  1};
    tbl[4]  = '{32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80,  4,  1};
    tbl[5]  = '{32'h100, 1, 32'h100, 0, 32'h80,  1, 32'h80,  1, 32'h80,  1, 32'h104, 5,  2};
    tbl[6]  = '{32'h100, 0, 32'h100, 0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h104, 5,  2};
    tbl[7]  = '{32'h100, 1, 32'h100, 0, 32'h80,  1, 32'h80,  1, 32'h80,  1, 32'h104, 6,  3};
    tbl[8]  = '{32'h100, 1, 32'h100, 0, 32'h80,  0, 32'h104, 0, 32'h104, 0, 32'h104, 7,  3};
    tbl[9]  = '{32'h100, 0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h104, 7,  3};
    tbl[10] = '{32'h100, 1, 32'h100, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80,  8,  4};
    tbl[11] = '{32'h100, 1, 32'h100, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80,  9,  5};
    tbl[12] = '{32'h100, 1, 32'h100, 1, 32'h90,  1, 32'h80,  1, 32'h80,  1, 32'h90,  10, 6};
    tbl[13] = '{32'h100, 0, 32'h100, 0, 32'h0,   0, 32'h0,   1, 32'h90,  0, 32'h104, 10, 6};
    tbl[14] = '{32'h100, 1, 32'h140, 1, 32'h200, 0, 32'h144, 1, 32'h90,  1, 32'h200, 11, 7};
    tbl[15] = '{32'h100, 0, 32'h140, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h144, 11, 7};
    tbl[16] = '{32'h140, 0, 32'h140, 0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h144, 11, 7};
    tbl[17] = '{32'h140, 1, 32'h140, 1, 32'h300, 1, 32'h200, 1, 32'h200, 1, 32'h300, 12, 8};
    tbl[18] = '{32'h140, 0, 32'h140, 0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 32'h144, 12, 8};
  end

  // random-phase locals
  logic [31:0] r_fpc, r_upc, r_tg, r_ptg;
  logic        r_rst, r_v, r_t, r_pt, r_st;
  bit          e_pt;
  int unsigned e_tg;

  initial begin
    rst = 1'b1;
    idle_fetch(32'h100);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_br_count", bif.br_count_o, 32'h0);
    chk("reset_mis_count", bif.mispred_count_o, 32'h0);

    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k].fpc, tbl[k].v, tbl[k].upc, tbl[k].t, tbl[k].tg, tbl[k].pt, tbl[k].ptg, 1'b0);
      #1;
      chk($sformatf("vec%0d_pred_taken", k), 32'(bif.pred_taken_o), 32'(tbl[k].e_pt));
      chk($sformatf("vec%0d_pred_target", k), bif.pred_target_o, tbl[k].e_ptg);
      chk($sformatf("vec%0d_mispredict", k), 32'(bif.mispredict_o), 32'(tbl[k].e_mis));
      chk($sformatf("vec%0d_redirect", k), bif.redirect_addr_o, tbl[k].e_red);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_br_count", k), bif.br_count_o, tbl[k].e_br);
      chk($sformatf("vec%0d_mis_count", k), bif.mispred_count_o, tbl[k].e_mcnt);
    end

    // stalled update held 3 cycles, applied once when the stall drops
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(32'h180, 1'b1, 32'h180, 1'b1, 32'h400, 1'b0, 32'h184, 1'b1);
      #1;
      chk("stall_mispredict_held", 32'(bif.mispredict_o), 32'h1);
      chk("stall_pred_taken", 32'(bif.pred_taken_o), 32'h0);
      @(posedge clk); #1;
      chk("stall_br_frozen", bif.br_count_o, 32'd12);
    end
    @(negedge clk);
    bif.stall_i = 1'b0;
    @(posedge clk); #1;
    chk("stall_release_br", bif.br_count_o, 32'd13);
    chk("stall_release_mis", bif.mispred_count_o, 32'd9);
    @(negedge clk);
    idle_fetch(32'h180);
    #1;
    chk("stall_alloc_taken", 32'(bif.pred_taken_o), 32'h1);
    chk("stall_alloc_target", bif.pred_target_o, 32'h400);
    // one not-taken drops a freshly allocated counter to weak-NT
    @(negedge clk);
    drive(32'h180, 1'b1, 32'h180, 1'b0, 32'h0, 1'b1, 32'h400, 1'b0);
    @(posedge clk);
    @(negedge clk);
    idle_fetch(32'h180);
    #1;
    chk("stall_applied_once", 32'(bif.pred_taken_o), 32'h0);

    // counter wrap
    @(negedge clk);
    dut.br_cnt <= 32'hFFFF_FFFF;
    @(negedge clk);
    drive(32'h180, 1'b1, 32'h180, 1'b1, 32'h500, 1'b0, 32'h184, 1'b0);
    @(posedge clk); #1;
    chk("br_count_wrap", bif.br_count_o, 32'h0);

    // reset overrides a simultaneous update
    @(negedge clk);
    rst = 1'b1;
    drive(32'h1C0, 1'b1, 32'h1C0, 1'b1, 32'h600, 1'b0, 32'h1C4, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_fetch(32'h1C0);
    #1;
    chk("rst_update_br", bif.br_count_o, 32'h0);
    chk("rst_update_mis", bif.mispred_count_o, 32'h0);
    chk("rst_update_pred", 32'(bif.pred_taken_o), 32'h0);
    chk("rst_update_target", bif.pred_target_o, 32'h1C4);
    @(negedge clk);
    idle_fetch(32'h180);
    #1;
    chk("rst_empty_btb", 32'(bif.pred_taken_o), 32'h0);

    // reset mid-stall discards the held update
    @(negedge clk);
    drive(32'h200, 1'b1, 32'h200, 1'b1, 32'h700, 1'b0, 32'h204, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_fetch(32'h200);
    @(posedge clk); #1;
    chk("rst_stall_br", bif.br_count_o, 32'h0);
    chk("rst_stall_pred", 32'(bif.pred_taken_o), 32'h0);

    // random traffic vs reference model
    @(negedge clk);
    rst = 1'b1;
    idle_fetch(32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      r_rst = ($urandom_range(0, 49) == 0);
      r_st  = ($urandom_range(0, 4) == 0);
      r_v   = ($urandom_range(0, 3) != 0);
      r_fpc = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2);
      r_upc = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2);
      r_t   = 1'($urandom_range(0, 1));
      r_tg  = 32'h1000 + ($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 3) != 0) begin
        m_predict(r_upc, e_pt, e_tg);
        r_pt = e_pt; r_ptg = e_tg;
      end else begin
        r_pt = 1'($urandom_range(0, 1)); r_ptg = 32'h1000 + ($urandom_range(0, 3) << 2);
      end
      rst = r_rst;
      drive(r_fpc, r_v, r_upc, r_t, r_tg, r_pt, r_ptg, r_st);
      #1;
      m_predict(r_fpc, e_pt, e_tg);
      chk("rnd_pred_taken", 32'(bif.pred_taken_o), 32'(e_pt));
      chk("rnd_pred_target", bif.pred_target_o, e_tg);
      chk("rnd_mispredict", 32'(bif.mispredict_o), 32'(m_mispred(r_v, r_t, r_tg, r_pt, r_ptg)));
      chk("rnd_redirect", bif.redirect_addr_o, r_t ? r_tg : r_upc + 32'd4);
      @(posedge clk);
      m_commit(r_rst, r_v, r_st, r_upc, r_t, r_tg, r_pt, r_ptg);
      #1;
      chk("rnd_br_count", bif.br_count_o, m_br);
      chk("rnd_mis_count", bif.mispred_count_o, m_mis);
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
